// File: rtl/inst_boot_loader.sv
// Instruction-memory boot loader: streams a counted image into Inst_mem,
// holds the core in reset for HOLD_CYC cycles, then releases it.
module inst_boot_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int STRIDE    = 4,
    parameter int BASE_ADDR = 0,
    parameter int HOLD_CYC  = 2,
    parameter int LEN_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  word_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              rst_n_cpu,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [7:0]        HOLD_L   = 8'(HOLD_CYC - 1);

    state_t              state_r, state_nx_s;
    logic [LEN_W-1:0]    cnt_r, cnt_nx_s;
    logic [LEN_W-1:0]    len_r, len_nx_s;
    logic [7:0]          hold_r, hold_nx_s;
    logic [DATA_W-1:0]   chk_r, chk_nx_s;
    logic                err_r, err_nx_s;
    logic                rst_n_cpu_r, busy_r, done_r;
    logic                beat_s;
    logic [ADDR_W-1:0]   load_addr_s;

    // Stream handshake, load address and Inst_mem port mux
    always_comb begin
        in_ready    = (state_r == ST_LOAD);
        beat_s      = in_ready & in_valid;
        load_addr_s = BASE_A + (ADDR_W'(cnt_r) * STRIDE_A);
        mem_wr_en   = beat_s;
        mem_wdata   = in_data;
        if (state_r == ST_LOAD) begin
            mem_addr = load_addr_s;
        end else begin
            mem_addr = cpu_addr;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        len_nx_s   = len_r;
        hold_nx_s  = hold_r;
        chk_nx_s   = chk_r;
        err_nx_s   = err_r;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    if (word_len > DEPTH_L) begin
                        err_nx_s   = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else if (word_len == LEN_ZERO) begin
                        err_nx_s   = 1'b0;
                        hold_nx_s  = 8'd0;
                        state_nx_s = ST_HOLD;
                    end else begin
                        err_nx_s   = 1'b0;
                        chk_nx_s   = {DATA_W{1'b0}};
                        cnt_nx_s   = LEN_ZERO;
                        len_nx_s   = word_len;
                        state_nx_s = ST_LOAD;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    cnt_nx_s = cnt_r + LEN_ONE;
                    chk_nx_s = chk_r + in_data;
                    if (cnt_r == (len_r - LEN_ONE)) begin
                        hold_nx_s  = 8'd0;
                        state_nx_s = ST_HOLD;
                    end else begin
                        state_nx_s = ST_LOAD;
                    end
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_r == HOLD_L) begin
                    state_nx_s = ST_RUN;
                end else begin
                    hold_nx_s  = hold_r + 8'd1;
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= LEN_ZERO;
            len_r       <= LEN_ZERO;
            hold_r      <= 8'd0;
            chk_r       <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
            rst_n_cpu_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            len_r       <= len_nx_s;
            hold_r      <= hold_nx_s;
            chk_r       <= chk_nx_s;
            err_r       <= err_nx_s;
            rst_n_cpu_r <= (state_nx_s == ST_RUN);
            done_r      <= (state_nx_s == ST_RUN);
            busy_r      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_HOLD);
        end
    end

    assign rst_n_cpu = rst_n_cpu_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign checksum  = chk_r;

endmodule
